exe_issue_sched: RTL
====================

Name: exe_issue_sched

Overview:
Issue scheduler for the single shared EXE unit (ALU, branch compare, HI/LO mult/div). It arbitrates round-robin among NUM_REQ reservation-station requesters and grants one per cycle. It blocks the unit for DIV_LAT cycles after a multi-cycle HI/LO op, and inserts a one-cycle bubble on a branch flush from EXE. It sits between the reservation stations and the EXE input latch.

Parameters:
NUM_REQ, 4, number of requesting reservation stations (2..8)
TAG_W, 6, ROB tag width carried with each request
DIV_LAT, 8, total EXE occupancy in cycles of a multi-cycle op; must be >=2 (elaboration error otherwise)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  requester i holds a ready instruction
req_multi  in  NUM_REQ  requester i's instruction is a multi-cycle HI/LO op
req_tag  in  NUM_REQ*TAG_W  packed tags; slice i = [i*TAG_W +: TAG_W]
stall  in  1  downstream (MEM) cannot accept; suppress new grants
flush  in  1  branch redirect from EXE (Request_Alt_PC)
grant  out  NUM_REQ  combinational one-hot grant; requester pops on grant
issue_valid  out  1  registered: instruction enters EXE this cycle
issue_tag  out  TAG_W  registered tag of issued instruction
issue_src  out  clog2(NUM_REQ)  registered winner index
exe_busy  out  1  registered: state != READY

Behaviour:
- States: READY, MULTI, FLUSH. Registers: state, rr_ptr, cnt (clog2(DIV_LAT) bits), issue_*.
- Reset (RESET low, asynchronous): state=READY, rr_ptr=0, cnt=0, issue_valid=0, issue_tag=0, issue_src=0, exe_busy=0. grant is 0 while RESET is low.
- Grant eligibility: state==READY && !stall && !flush. When eligible, the winner is the first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... with wrap mod NUM_REQ. grant is 0 when no request is valid.
- On grant (clock edge): rr_ptr <= (winner+1) mod NUM_REQ; issue_valid<=1, issue_tag<=req_tag[winner], issue_src<=winner. If req_multi[winner], state<=MULTI and cnt<=DIV_LAT-1.
- No grant: issue_valid<=0; issue_tag and issue_src hold their values; rr_ptr holds.
- Latency: request seen with grant in cycle t; issue_valid high in cycle t+1.
- MULTI: no grants. cnt decrements every cycle regardless of stall. When cnt==1, state<=READY, so the next grant is possible DIV_LAT cycles after the multi grant.
- FLUSH: entered from any state when flush=1. cnt<=0, issue_valid<=0, no grant. Exactly one cycle, then READY. Flush in the FLUSH state stays in FLUSH.
- Priority of simultaneous events: reset > flush > MULTI countdown > stall > grant.
- stall with no flush in READY: no grant, rr_ptr unchanged, issue_valid<=0.
- Reset mid-MULTI: immediate return to READY; the countdown is abandoned.

Optional Feature:
Macro EXE_SCHED_PERF_EN.
- Defined: adds outputs perf_grants, perf_stall_cyc and perf_busy_cyc, each 32 bits, saturating at 32'hFFFFFFFF, cleared by RESET.
  - perf_grants counts issued grants.
  - perf_stall_cyc counts READY cycles with stall=1 and at least one req_valid.
  - perf_busy_cyc counts cycles spent in MULTI.
- Not defined: the same ports exist, tied to 0, with no counter flops.

Decomposition:
- Package exe_sched_pkg: state encoding constants (READY=2'd0, MULTI=2'd1, FLUSH=2'd2), default TAG_W, clog2 function.
- Sub-module rr_pick: combinational round-robin picker. Inputs are req vector and rr_ptr; outputs are one-hot, index and any_valid. It uses the masked double-scan method.
- All state and counters stay in exe_issue_sched.

Test Plan:
- NUM_REQ=4, rr_ptr=0, req_valid=4'b1010 held for 3 cycles -> grants 4'b0010, 4'b1000, 4'b0010; issue_src 1,3,1 one cycle later.
- req 2 with req_multi=1 granted at t, req_valid=4'b1111 held -> no grant t+1..t+7, exe_busy=1 t+1..t+7, next grant at t+8 (DIV_LAT=8) to req 3.
- flush at t+3 of a MULTI op -> state FLUSH t+4 (issue_valid=0), READY t+5, grant possible at t+5.
- req_valid=4'b0001 with stall=1 for 2 cycles -> grant=0, issue_valid=0, rr_ptr unchanged; stall drop -> grant 4'b0001.
- flush and req_valid=4'b0100 in the same cycle -> grant=0, issue_valid=0 next cycle, req 2 granted the cycle after FLUSH.
- RESET low during MULTI (cnt=5) -> immediately exe_busy=0, issue_valid=0, rr_ptr=0; with EXE_SCHED_PERF_EN, perf counters read 0.

Source files
------------

// File: rtl/exe_sched_pkg.sv
// Shared definitions for the EXE issue scheduler: state encoding, default
// tag width and a constant clog2 helper used for register sizing.
package exe_sched_pkg;

   typedef enum logic [1:0] {
      READY = 2'd0,
      MULTI = 2'd1,
      FLUSH = 2'd2
   } sched_state_t;

   localparam int DEF_TAG_W = 6;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) res++;
      return res;
   endfunction

endpackage

// File: rtl/exe_issue_sched_rr_pick.sv
// Combinational round-robin picker: lowest set request at or above ptr,
// falling back to the lowest set request overall (masked double scan).
module rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] onehot,
   output logic [W-1:0] idx,
   output logic         any_valid
);

   logic [N-1:0] masked;
   logic         found;

   always_comb begin
      masked = '0;
      for (int i = 0; i < N; i++) begin
         masked[i] = req[i] & (W'(i) >= ptr);
      end
   end

   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (masked[i] && !found) begin
            idx   = W'(i);
            found = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (req[i] && !found) begin
            idx   = W'(i);
            found = 1'b1;
         end
      end
   end

   assign any_valid = |req;

   always_comb begin
      onehot = '0;
      if (any_valid) onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/exe_issue_sched.sv
// Issue scheduler for the shared EXE unit: round-robin grant, multi-cycle
// occupancy lockout and flush bubble. Optional perf counters: EXE_SCHED_PERF_EN.
//
// state | meaning
// ------+-------------------------------------------------------------
// READY | unit free; grant the round-robin winner unless stall/flush
// MULTI | HI/LO op occupying the unit; cnt counts down to 1
// FLUSH | one-cycle bubble after a branch redirect
module exe_issue_sched
   import exe_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = DEF_TAG_W,
   parameter int DIV_LAT = 8
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ-1:0]         req_multi,
   input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
   input  logic                       stall,
   input  logic                       flush,
   output logic [NUM_REQ-1:0]         grant,
   output logic                       issue_valid,
   output logic [TAG_W-1:0]           issue_tag,
   output logic [clog2(NUM_REQ)-1:0]  issue_src,
   output logic                       exe_busy,
   output logic [31:0]                perf_grants,
   output logic [31:0]                perf_stall_cyc,
   output logic [31:0]                perf_busy_cyc
);

   localparam int IDX_W = clog2(NUM_REQ);
   localparam int CNT_W = clog2(DIV_LAT);

   generate
      if (DIV_LAT < 2) begin : g_bad_lat
         $error("exe_issue_sched: DIV_LAT must be >= 2");
      end
   endgenerate

   sched_state_t       state, state_nxt;
   logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               issue_valid_nxt;
   logic [TAG_W-1:0]   issue_tag_nxt;
   logic [IDX_W-1:0]   issue_src_nxt;

   logic [NUM_REQ-1:0] pick_onehot;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic               grant_en;

   rr_pick #(
      .N (NUM_REQ),
      .W (IDX_W)
   ) u_rr_pick (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .onehot    (pick_onehot),
      .idx       (pick_idx),
      .any_valid (pick_any)
   );

   // RESET gates the grant so requesters never pop while the scheduler is held.
   assign grant_en = RESET && (state == READY) && !stall && !flush && pick_any;
   assign grant    = grant_en ? pick_onehot : '0;

   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      rr_ptr_nxt      = rr_ptr;
      issue_valid_nxt = 1'b0;
      issue_tag_nxt   = issue_tag;
      issue_src_nxt   = issue_src;
      if (flush) begin
         state_nxt = FLUSH;
         cnt_nxt   = '0;
      end else begin
         case (state)
            MULTI: begin
               cnt_nxt = cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) state_nxt = READY;
            end
            FLUSH: state_nxt = READY;
            default: begin
               if (grant_en) begin
                  rr_ptr_nxt      = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
                  issue_valid_nxt = 1'b1;
                  issue_tag_nxt   = req_tag[pick_idx*TAG_W +: TAG_W];
                  issue_src_nxt   = pick_idx;
                  if (req_multi[pick_idx]) begin
                     state_nxt = MULTI;
                     cnt_nxt   = CNT_W'(DIV_LAT - 1);
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state       <= READY;
         rr_ptr      <= '0;
         cnt         <= '0;
         issue_valid <= 1'b0;
         issue_tag   <= '0;
         issue_src   <= '0;
         exe_busy    <= 1'b0;
      end else begin
         state       <= state_nxt;
         rr_ptr      <= rr_ptr_nxt;
         cnt         <= cnt_nxt;
         issue_valid <= issue_valid_nxt;
         issue_tag   <= issue_tag_nxt;
         issue_src   <= issue_src_nxt;
         exe_busy    <= (state_nxt != READY);
      end
   end

`ifdef EXE_SCHED_PERF_EN
   logic stall_hit;
   assign stall_hit = (state == READY) && stall && pick_any;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         perf_grants    <= '0;
         perf_stall_cyc <= '0;
         perf_busy_cyc  <= '0;
      end else begin
         if (grant_en && (perf_grants != 32'hFFFF_FFFF))
            perf_grants <= perf_grants + 32'd1;
         if (stall_hit && (perf_stall_cyc != 32'hFFFF_FFFF))
            perf_stall_cyc <= perf_stall_cyc + 32'd1;
         if ((state == MULTI) && (perf_busy_cyc != 32'hFFFF_FFFF))
            perf_busy_cyc <= perf_busy_cyc + 32'd1;
      end
   end
`else
   assign perf_grants    = '0;
   assign perf_stall_cyc = '0;
   assign perf_busy_cyc  = '0;
`endif

endmodule
